// File: rtl/dual_update.sv
// dual_update: ADMM dual-variable update stage.
// Per element: y <- sat(y + u - z) over the U section, then g <- sat(g + x - v)
// over the X section, written back in place, while tracking the running
// infinity-norm primal residuals max|u-z| and max|x-v|.
// Optional build macro: DUAL_UPDATE_RHO_SHIFT_EN adds input rho_shift[5:0];
// each difference is arithmetic-right-shifted by rho_shift before the add
// (residuals always use the unshifted difference).
module dual_update #(
    parameter int STATE_DIM  = 6,
    parameter int INPUT_DIM  = 3,
    parameter int HORIZON    = 30,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 9,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           active_horizon,
`ifdef DUAL_UPDATE_RHO_SHIFT_EN
    input  logic [5:0]            rho_shift,
`endif
    output logic [ADDR_WIDTH-1:0] u_rdaddress,
    output logic [ADDR_WIDTH-1:0] z_rdaddress,
    output logic [ADDR_WIDTH-1:0] y_rdaddress,
    input  logic [DATA_WIDTH-1:0] u_data_out,
    input  logic [DATA_WIDTH-1:0] z_data_out,
    input  logic [DATA_WIDTH-1:0] y_data_out,
    output logic [ADDR_WIDTH-1:0] x_rdaddress,
    output logic [ADDR_WIDTH-1:0] v_rdaddress,
    output logic [ADDR_WIDTH-1:0] g_rdaddress,
    input  logic [DATA_WIDTH-1:0] x_data_out,
    input  logic [DATA_WIDTH-1:0] v_data_out,
    input  logic [DATA_WIDTH-1:0] g_data_out,
    output logic [ADDR_WIDTH-1:0] y_wraddress,
    output logic [DATA_WIDTH-1:0] y_data_in,
    output logic                  y_wren,
    output logic [ADDR_WIDTH-1:0] g_wraddress,
    output logic [DATA_WIDTH-1:0] g_data_in,
    output logic                  g_wren,
    output logic [DATA_WIDTH-1:0] prim_res_u,
    output logic [DATA_WIDTH-1:0] prim_res_x,
    output logic                  busy,
    output logic                  done
);

    localparam int DW = DATA_WIDTH;

    localparam logic [DW-1:0]          SAT_MAX = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]          SAT_MIN = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [DW+1:0]   SUM_MAX = $signed({3'b000, {(DW-1){1'b1}}});
    localparam logic signed [DW+1:0]   SUM_MIN = $signed({3'b111, {(DW-1){1'b0}}});
    localparam logic [DW:0]            ABS_MAX = {2'b00, {(DW-1){1'b1}}};
    localparam logic [2:0]             WAIT_LAST = 3'(RD_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        U_RD,
        U_WAIT,
        U_WR,
        X_RD,
        X_WAIT,
        X_WR,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] idx;
    logic [31:0] u_cnt;
    logic [31:0] x_cnt;
    logic [2:0]  wait_cnt;

    logic [31:0] neff;
    logic [31:0] nu_calc;
    logic [31:0] nx_calc;
    logic [31:0] idx_inc;
    logic [5:0]  shamt;

    logic [DW-1:0] y_next;
    logic [DW-1:0] g_next;
    logic [DW-1:0] u_abs;
    logic [DW-1:0] x_abs;

`ifdef DUAL_UPDATE_RHO_SHIFT_EN
    assign shamt = rho_shift;
`else
    assign shamt = '0;
`endif

    // acc + ((a - b) >>> sh), widened to DW+2 bits and clamped to the signed range
    function automatic logic [DW-1:0] sat_update(input logic [DW-1:0] acc,
                                                 input logic [DW-1:0] a,
                                                 input logic [DW-1:0] b,
                                                 input logic [5:0]    sh);
        logic signed [DW:0]   d;
        logic signed [DW+1:0] s;
        d = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
        d = d >>> sh;
        s = $signed({{2{acc[DW-1]}}, acc}) + $signed({d[DW], d});
        if (s > SUM_MAX) begin
            return SAT_MAX;
        end else if (s < SUM_MIN) begin
            return SAT_MIN;
        end else begin
            return s[DW-1:0];
        end
    endfunction

    // |a - b| in DW+1 bits, clamped to the largest positive word
    function automatic logic [DW-1:0] sat_absdiff(input logic [DW-1:0] a,
                                                  input logic [DW-1:0] b);
        logic signed [DW:0] d;
        logic [DW:0]        m;
        d = $signed({a[DW-1], a}) - $signed({b[DW-1], b});
        m = d[DW] ? $unsigned(-d) : $unsigned(d);
        if (m > ABS_MAX) begin
            return SAT_MAX;
        end else begin
            return m[DW-1:0];
        end
    endfunction

    assign y_next  = sat_update(y_data_out, u_data_out, z_data_out, shamt);
    assign g_next  = sat_update(g_data_out, x_data_out, v_data_out, shamt);
    assign u_abs   = sat_absdiff(u_data_out, z_data_out);
    assign x_abs   = sat_absdiff(x_data_out, v_data_out);
    assign idx_inc = idx + 32'd1;

    // Clamp the requested horizon and derive the per-section element counts
    always_comb begin
        neff    = (active_horizon > 32'(HORIZON)) ? 32'(HORIZON) : active_horizon;
        nu_calc = '0;
        if (neff > 32'd1) begin
            nu_calc = 32'(INPUT_DIM) * (neff - 32'd1);
        end
        nx_calc = 32'(STATE_DIM) * neff;
    end

    // Pass sequencer: read, wait for memory latency, write back, per element
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            u_cnt       <= '0;
            x_cnt       <= '0;
            wait_cnt    <= '0;
            u_rdaddress <= '0;
            z_rdaddress <= '0;
            y_rdaddress <= '0;
            x_rdaddress <= '0;
            v_rdaddress <= '0;
            g_rdaddress <= '0;
            y_wraddress <= '0;
            y_data_in   <= '0;
            y_wren      <= 1'b0;
            g_wraddress <= '0;
            g_data_in   <= '0;
            g_wren      <= 1'b0;
            prim_res_u  <= '0;
            prim_res_x  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        u_cnt       <= nu_calc;
                        x_cnt       <= nx_calc;
                        idx         <= '0;
                        prim_res_u  <= '0;
                        prim_res_x  <= '0;
                        u_rdaddress <= '0;
                        z_rdaddress <= '0;
                        y_rdaddress <= '0;
                        x_rdaddress <= '0;
                        v_rdaddress <= '0;
                        g_rdaddress <= '0;
                        if (nu_calc != '0) begin
                            busy  <= 1'b1;
                            state <= U_RD;
                        end else if (nx_calc != '0) begin
                            busy  <= 1'b1;
                            state <= X_RD;
                        end else begin
                            // empty pass: straight to completion
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                U_RD: begin
                    wait_cnt <= 3'd1;
                    state    <= U_WAIT;
                end
                U_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        y_wren      <= 1'b1;
                        y_wraddress <= idx[ADDR_WIDTH-1:0];
                        y_data_in   <= y_next;
                        if (u_abs > prim_res_u) begin
                            prim_res_u <= u_abs;
                        end
                        state <= U_WR;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                U_WR: begin
                    y_wren <= 1'b0;
                    if (idx == u_cnt - 32'd1) begin
                        idx <= '0;
                        if (x_cnt != '0) begin
                            x_rdaddress <= '0;
                            v_rdaddress <= '0;
                            g_rdaddress <= '0;
                            state       <= X_RD;
                        end else begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        idx         <= idx_inc;
                        u_rdaddress <= idx_inc[ADDR_WIDTH-1:0];
                        z_rdaddress <= idx_inc[ADDR_WIDTH-1:0];
                        y_rdaddress <= idx_inc[ADDR_WIDTH-1:0];
                        state       <= U_RD;
                    end
                end
                X_RD: begin
                    wait_cnt <= 3'd1;
                    state    <= X_WAIT;
                end
                X_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        g_wren      <= 1'b1;
                        g_wraddress <= idx[ADDR_WIDTH-1:0];
                        g_data_in   <= g_next;
                        if (x_abs > prim_res_x) begin
                            prim_res_x <= x_abs;
                        end
                        state <= X_WR;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                X_WR: begin
                    g_wren <= 1'b0;
                    if (idx == x_cnt - 32'd1) begin
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx         <= idx_inc;
                        x_rdaddress <= idx_inc[ADDR_WIDTH-1:0];
                        v_rdaddress <= idx_inc[ADDR_WIDTH-1:0];
                        g_rdaddress <= idx_inc[ADDR_WIDTH-1:0];
                        state       <= X_RD;
                    end
                end
                DONE: begin
                    if (!start) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dual_update.sv
// tb_dual_update: randomized self-checking bench for dual_update with
// behavioural memories and a wide-integer reference model.
module tb_dual_update;

    localparam int DW   = 64;
    localparam int AW   = 9;
    localparam int NXD  = 6;
    localparam int NUD  = 3;
    localparam int HOR  = 30;
    localparam int RDL  = 2;
    localparam int NMEM = 512;

    localparam logic [63:0]         POS_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] BIG_MAX = 128'sh7FFF_FFFF_FFFF_FFFF;
    localparam logic signed [127:0] BIG_MIN = -BIG_MAX - 128'sd1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [31:0]   active_horizon = '0;
`ifdef DUAL_UPDATE_RHO_SHIFT_EN
    logic [5:0]    rho_shift = '0;
`endif
    logic [AW-1:0] u_rdaddress, z_rdaddress, y_rdaddress;
    logic [AW-1:0] x_rdaddress, v_rdaddress, g_rdaddress;
    logic [DW-1:0] u_data_out, z_data_out, y_data_out;
    logic [DW-1:0] x_data_out, v_data_out, g_data_out;
    logic [AW-1:0] y_wraddress, g_wraddress;
    logic [DW-1:0] y_data_in, g_data_in;
    logic          y_wren, g_wren;
    logic [DW-1:0] prim_res_u, prim_res_x;
    logic          busy, done;

    // memories: 0=u 1=z 2=y 3=x 4=v 5=g
    logic [63:0] mem [6][NMEM];
    logic [63:0] p1 [6];
    logic [63:0] p2 [6];
    logic [63:0] y_exp [NMEM];
    logic [63:0] g_exp [NMEM];
    logic [63:0] exp_ru, exp_rx;
    int          nu_e, nx_e;
    int          sh = 0;
    int          n_vec = 0;
    int          n_err = 0;

    dual_update #(
        .STATE_DIM (NXD),
        .INPUT_DIM (NUD),
        .HORIZON   (HOR),
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .RD_LATENCY(RDL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .active_horizon(active_horizon),
`ifdef DUAL_UPDATE_RHO_SHIFT_EN
        .rho_shift     (rho_shift),
`endif
        .u_rdaddress   (u_rdaddress),
        .z_rdaddress   (z_rdaddress),
        .y_rdaddress   (y_rdaddress),
        .u_data_out    (u_data_out),
        .z_data_out    (z_data_out),
        .y_data_out    (y_data_out),
        .x_rdaddress   (x_rdaddress),
        .v_rdaddress   (v_rdaddress),
        .g_rdaddress   (g_rdaddress),
        .x_data_out    (x_data_out),
        .v_data_out    (v_data_out),
        .g_data_out    (g_data_out),
        .y_wraddress   (y_wraddress),
        .y_data_in     (y_data_in),
        .y_wren        (y_wren),
        .g_wraddress   (g_wraddress),
        .g_data_in     (g_data_in),
        .g_wren        (g_wren),
        .prim_res_u    (prim_res_u),
        .prim_res_x    (prim_res_x),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    // two-stage registered read path (RD_LATENCY = 2)
    always @(posedge clk) begin
        p1[0] <= mem[0][u_rdaddress];
        p1[1] <= mem[1][z_rdaddress];
        p1[2] <= mem[2][y_rdaddress];
        p1[3] <= mem[3][x_rdaddress];
        p1[4] <= mem[4][v_rdaddress];
        p1[5] <= mem[5][g_rdaddress];
        p2    <= p1;
    end

    assign u_data_out = p2[0];
    assign z_data_out = p2[1];
    assign y_data_out = p2[2];
    assign x_data_out = p2[3];
    assign v_data_out = p2[4];
    assign g_data_out = p2[5];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_upd(input logic signed [63:0] acc,
                                            input logic signed [63:0] a,
                                            input logic signed [63:0] b,
                                            input int s);
        logic signed [127:0] d;
        logic signed [127:0] r;
        d = a;
        d = d - b;
        d = d >>> s;
        r = d + acc;
        if (r > BIG_MAX) r = BIG_MAX;
        if (r < BIG_MIN) r = BIG_MIN;
        return r[63:0];
    endfunction

    function automatic logic [63:0] ref_abs(input logic signed [63:0] a,
                                            input logic signed [63:0] b);
        logic signed [127:0] d;
        d = a;
        d = d - b;
        if (d < 0) d = -d;
        if (d > BIG_MAX) d = BIG_MAX;
        return d[63:0];
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] r;
        case ($urandom_range(0, 3))
            0:       r = 64'($urandom_range(0, 2000)) - 64'd1000;
            1:       r = {$urandom, $urandom};
            2:       r = POS_MAX - 64'($urandom_range(0, 50));
            default: r = 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 50));
        endcase
        return r;
    endfunction

    task automatic fill(input int pat);
        for (int i = 0; i < NMEM; i++) begin
            for (int k = 0; k < 6; k++) mem[k][i] = rnd64();
            case (pat)
                0: begin
                    mem[0][i] = 64'd5; mem[1][i] = 64'd2; mem[2][i] = 64'd0;
                    mem[3][i] = 64'd7; mem[4][i] = 64'd7; mem[5][i] = 64'd0;
                end
                1: begin
                    mem[0][i] = (i == 3) ? 64'h8000_0000_0000_0000 : 64'd100;
                    mem[1][i] = (i == 3) ? 64'd1 : 64'd0;
                    mem[2][i] = POS_MAX - 64'd9;
                end
                3: begin
                    mem[0][i] = 64'd0; mem[1][i] = 64'd12; mem[2][i] = 64'd1;
                end
                default: ;
            endcase
        end
    endtask

    task automatic build_model(input int hor);
        int          neff;
        logic [63:0] a;
        neff   = (hor > HOR) ? HOR : hor;
        nu_e   = (neff > 1) ? NUD * (neff - 1) : 0;
        nx_e   = NXD * neff;
        exp_ru = '0;
        exp_rx = '0;
        for (int i = 0; i < NMEM; i++) begin
            y_exp[i] = mem[2][i];
            g_exp[i] = mem[5][i];
        end
        for (int i = 0; i < nu_e; i++) begin
            y_exp[i] = ref_upd(mem[2][i], mem[0][i], mem[1][i], sh);
            a = ref_abs(mem[0][i], mem[1][i]);
            if (a > exp_ru) exp_ru = a;
        end
        for (int i = 0; i < nx_e; i++) begin
            g_exp[i] = ref_upd(mem[5][i], mem[3][i], mem[4][i], sh);
            a = ref_abs(mem[3][i], mem[4][i]);
            if (a > exp_rx) exp_rx = a;
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_u_rdaddr"}, 64'(u_rdaddress), 64'd0);
        check({pfx, "_z_rdaddr"}, 64'(z_rdaddress), 64'd0);
        check({pfx, "_y_rdaddr"}, 64'(y_rdaddress), 64'd0);
        check({pfx, "_x_rdaddr"}, 64'(x_rdaddress), 64'd0);
        check({pfx, "_v_rdaddr"}, 64'(v_rdaddress), 64'd0);
        check({pfx, "_g_rdaddr"}, 64'(g_rdaddress), 64'd0);
        check({pfx, "_y_wraddr"}, 64'(y_wraddress), 64'd0);
        check({pfx, "_g_wraddr"}, 64'(g_wraddress), 64'd0);
        check({pfx, "_y_data_in"}, y_data_in, 64'd0);
        check({pfx, "_g_data_in"}, g_data_in, 64'd0);
        check({pfx, "_y_wren"}, 64'(y_wren), 64'd0);
        check({pfx, "_g_wren"}, 64'(g_wren), 64'd0);
        check({pfx, "_prim_res_u"}, prim_res_u, 64'd0);
        check({pfx, "_prim_res_x"}, prim_res_x, 64'd0);
        check({pfx, "_busy"}, 64'(busy), 64'd0);
        check({pfx, "_done"}, 64'(done), 64'd0);
    endtask

    // One full pass; with hold=1 start stays high through the pass and DONE
    task automatic run_pass(input int hor, input bit hold);
        int n  = 0;
        int yi = 0;
        int gi = 0;
        bit fin = 1'b0;
        build_model(hor);
        @(negedge clk);
        active_horizon = 32'(hor);
        start = 1'b1;
        while (!fin && n < 4000) begin
            @(negedge clk);
            n++;
            if (!hold) start = 1'b0;
            if (y_wren) begin
                if (yi < nu_e) begin
                    check("y_wraddr", 64'(y_wraddress), 64'(yi));
                    check("y_data_in", y_data_in, y_exp[yi]);
                end else begin
                    check("y_extra_write", 64'(yi + 1), 64'(nu_e));
                end
                mem[2][y_wraddress] = y_data_in;
                yi++;
            end
            if (g_wren) begin
                check("g_after_y", 64'(yi), 64'(nu_e));
                if (gi < nx_e) begin
                    check("g_wraddr", 64'(g_wraddress), 64'(gi));
                    check("g_data_in", g_data_in, g_exp[gi]);
                end else begin
                    check("g_extra_write", 64'(gi + 1), 64'(nx_e));
                end
                mem[5][g_wraddress] = g_data_in;
                gi++;
            end
            if (done) fin = 1'b1;
        end
        check("done_seen", 64'(fin), 64'd1);
        check("done_cycle", 64'(n), 64'((RDL + 2) * (nu_e + nx_e) + 1));
        check("y_write_count", 64'(yi), 64'(nu_e));
        check("g_write_count", 64'(gi), 64'(nx_e));
        check("prim_res_u", prim_res_u, exp_ru);
        check("prim_res_x", prim_res_x, exp_rx);
        check("busy_at_done", 64'(busy), 64'd0);
        for (int i = 0; i < 200; i++) begin
            check("y_mem", mem[2][i], y_exp[i]);
            check("g_mem", mem[5][i], g_exp[i]);
        end
        if (hold) begin
            repeat (4) begin
                @(negedge clk);
                check("hold_done", 64'(done), 64'd1);
                check("hold_no_wren", 64'(y_wren | g_wren), 64'd0);
                check("hold_res_u", prim_res_u, exp_ru);
            end
            start = 1'b0;
        end
        @(negedge clk);
        check("done_cleared", 64'(done), 64'd0);
    endtask

    task automatic reset_mid_pass();
        int n  = 0;
        int yi = 0;
        bit noisy = 1'b0;
        fill(2);
        @(negedge clk);
        active_horizon = 32'(HOR);
        start = 1'b1;
        while (yi < 40 && n < 2000) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (y_wren) begin
                mem[2][y_wraddress] = y_data_in;
                yi++;
            end
        end
        check("rst_reached_40", 64'(yi), 64'd40);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (y_wren || g_wren || busy || done) noisy = 1'b1;
        end
        check("rst_quiet", 64'(noisy), 64'd0);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // constant pattern, full horizon
        fill(0);
        run_pass(HOR, 1'b0);
        check("const_y0", mem[2][0], 64'd3);
        check("const_g0", mem[5][0], 64'd0);
        check("const_res_u", prim_res_u, 64'd3);
        check("const_res_x", prim_res_x, 64'd0);

        // saturation of the update and of the residual
        fill(1);
        run_pass(5, 1'b0);
        check("sat_y0", mem[2][0], POS_MAX);
        check("sat_res_u", prim_res_u, POS_MAX);

        // horizon edges
        fill(2); run_pass(1, 1'b0);
        fill(2); run_pass(0, 1'b0);
        fill(2); run_pass(50, 1'b0);

        // abort mid-pass, then a clean pass
        reset_mid_pass();
        fill(2); run_pass(HOR, 1'b0);

        // start held through DONE, then a second pass must clear residuals
        fill(2); run_pass(HOR, 1'b1);
        fill(0); run_pass(8, 1'b0);
        check("cleared_res_u", prim_res_u, 64'd3);
        check("cleared_res_x", prim_res_x, 64'd0);

        repeat (3) begin
            fill(2);
            run_pass(int'($urandom_range(2, HOR)), 1'b0);
        end

`ifdef DUAL_UPDATE_RHO_SHIFT_EN
        sh = 2;
        rho_shift = 6'd2;
        fill(3);
        run_pass(4, 1'b0);
        check("shift_y0", mem[2][0], 64'hFFFF_FFFF_FFFF_FFFE);
        check("shift_res_u", prim_res_u, 64'd12);
        repeat (2) begin
            sh = int'($urandom_range(0, 63));
            rho_shift = 6'(sh);
            fill(2);
            run_pass(int'($urandom_range(2, HOR)), 1'b0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
